// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: shares one serial_transmitter among NUM_REQ byte-stream
// requesters. Round-robin grant is held for a whole message (until req_last or
// the MAX_MSG_BYTES limit), so messages never interleave on the line.
// Optional feature macro: SERIAL_TX_ARB_TAG_EN -- when defined, each grant first
// sends one ASCII tag byte ('0' + grant_id) before the requester's bytes.
module serial_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 3,
    parameter int unsigned MAX_MSG_BYTES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_available,
    input  logic                 tx_ready,
    output logic [2:0]           grant_id,
    output logic                 busy
);

    localparam int unsigned CNT_W = (MAX_MSG_BYTES > 0) ? $clog2(MAX_MSG_BYTES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TAG    = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               guard_q;

    logic               fire;
    logic               hit;
    logic [2:0]         hit_idx;
    logic [3:0]         idx_sum;
    logic [NUM_REQ-1:0] rot_valid;
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               limit_hit;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        rot_valid = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        hit       = 1'b0;
        hit_idx   = '0;
        idx_sum   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!hit && rot_valid[k]) begin
                hit     = 1'b1;
                idx_sum = 4'(ptr_q) + 4'(k);
                hit_idx = (idx_sum >= 4'(NUM_REQ)) ? 3'(idx_sum - 4'(NUM_REQ)) : 3'(idx_sum);
            end
        end
    end

    // Mux the granted requester's byte, valid and last flag.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                sel_data  = req_data[8*i +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    // Byte limit reached by the byte firing now (disabled when the limit is 0).
    always_comb begin
        limit_hit = (MAX_MSG_BYTES != 0) && ((32'(count_q) + 32'd1) == MAX_MSG_BYTES);
    end

    // Next-state and transmitter/requester handshake outputs.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        ptr_d             = ptr_q;
        count_d           = count_q;
        tx_data           = '0;
        tx_data_available = 1'b0;
        req_ready         = '0;
        fire              = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    grant_d = hit_idx;
`ifdef SERIAL_TX_ARB_TAG_EN
                    state_d = ST_TAG;
`else
                    state_d = ST_STREAM;
`endif
                end
            end
`ifdef SERIAL_TX_ARB_TAG_EN
            ST_TAG: begin
                tx_data           = 8'h30 + 8'(grant_q);
                tx_data_available = !guard_q;
                fire              = tx_data_available && tx_ready;
                if (fire) begin
                    state_d = ST_STREAM;
                end
            end
`endif
            ST_STREAM: begin
                tx_data           = sel_data;
                tx_data_available = sel_valid && !guard_q;
                fire              = tx_data_available && tx_ready;
                if (fire) begin
                    req_ready = NUM_REQ'(1) << grant_q;
                    count_d   = count_q + CNT_W'(1);
                    if (sel_last || limit_hit) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        ptr_d   = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer, byte count and back-to-back guard registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            guard_q <= fire;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed scenarios plus randomized traffic for
// serial_tx_arbiter, checked cycle by cycle against a message-level model.
`timescale 1ns/1ps
module tb_serial_tx_arbiter;

    localparam int unsigned N     = 3;
    localparam int unsigned MAXB  = 4;
    localparam int          FRAME = 10;
    localparam int          DEPTH = 1024;
`ifdef SERIAL_TX_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t [$];

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last  = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_data_available;
    logic           tx_ready = 1'b0;
    logic [2:0]     grant_id;
    logic           busy;

    serial_tx_arbiter #(.NUM_REQ(N), .MAX_MSG_BYTES(MAXB)) dut (
        .clock(clock), .reset(reset),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data),
        .tx_data_available(tx_data_available), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Requester byte stores: {last, data} plus idle gap after each byte.
    logic [8:0]  mem  [N][DEPTH];
    int unsigned gapm [N][DEPTH];
    int wr[N], rd[N], gap[N], m_rd[N];

    // Message-level reference model state.
    int m_owner = -1, m_ptr = 0, m_cnt = 0, m_last_grant = 0, m_fires = 0;
    bit m_tag = 1'b0, m_prev_fire = 1'b0;

    // Transmitter model: ready stays high one cycle after a fire, then a frame.
    int tx_hold = 0;
    bit just_fired = 1'b0;

    bq_t line_q, order_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_seq(input string tag, input bq_t got, input bq_t exp);
        check_eq({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check_eq(tag, 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input bit last, input int unsigned g);
        if (wr[i] < DEPTH) begin
            mem[i][wr[i]]  = {last, d};
            gapm[i][wr[i]] = g;
            wr[i]++;
        end
    endtask

    task automatic push_msg(input int i, input int len, input int gap_at, input int unsigned gap_len);
        for (int b = 0; b < len; b++)
            push_byte(i, 8'($urandom), b == len - 1, (b == gap_at && b < len - 1) ? gap_len : 0);
    endtask

    // Drive requester and transmitter inputs for the coming edge.
    task automatic drive_inputs();
        bit v;
        for (int i = 0; i < N; i++) begin
            v = (rd[i] < wr[i]) && (gap[i] == 0);
            req_valid[i]       = v;
            req_data[8*i +: 8] = v ? mem[i][rd[i]][7:0] : 8'($urandom);
            req_last[i]        = v ? mem[i][rd[i]][8] : 1'($urandom);
            if (gap[i] > 0) gap[i]--;
        end
        tx_ready = just_fired || (tx_hold == 0);
        if (just_fired) just_fired = 1'b0;
        else if (tx_hold > 0) tx_hold--;
    endtask

    // Compare DUT outputs with the model, then advance model and stimulus.
    task automatic sample_and_check();
        bit         fire, last, found;
        int         j;
        logic [N-1:0] er;
        fire = tx_data_available && tx_ready;
        if (m_prev_fire) check_eq("no_b2b_fire", fire, 0);
        check_eq("busy", busy, m_owner >= 0);
        check_eq("grant_id", grant_id, m_last_grant);
        if (m_owner < 0) begin
            check_eq("idle_avail", tx_data_available, 0);
            check_eq("idle_data", tx_data, 0);
            check_eq("idle_ready", req_ready, 0);
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (!found && req_valid[j]) begin
                    found        = 1'b1;
                    m_owner      = j;
                    m_last_grant = j;
                    m_tag        = TAG_EN;
                end
            end
        end else if (m_tag) begin
            check_eq("tag_avail", tx_data_available, !m_prev_fire);
            check_eq("tag_data", tx_data, 8'h30 + 8'(m_owner));
            check_eq("tag_ready", req_ready, 0);
            if (fire) m_tag = 1'b0;
        end else begin
            check_eq("stream_avail", tx_data_available, req_valid[m_owner] && !m_prev_fire);
            er = fire ? (N'(1) << m_owner) : '0;
            check_eq("req_ready", req_ready, er);
            if (req_valid[m_owner] && m_rd[m_owner] < wr[m_owner])
                check_eq("stream_data", tx_data, mem[m_owner][m_rd[m_owner]][7:0]);
            if (fire && m_rd[m_owner] < wr[m_owner]) begin
                last = mem[m_owner][m_rd[m_owner]][8];
                m_rd[m_owner]++;
                m_cnt++;
                m_fires++;
                if (last || m_cnt == MAXB) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_cnt   = 0;
                    m_owner = -1;
                end
            end
        end
        m_prev_fire = fire;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rd[i] < wr[i]) begin
                gap[i] = gapm[i][rd[i]];
                rd[i]++;
            end
        end
        if (fire) begin
            tx_hold    = FRAME;
            just_fired = 1'b1;
            line_q.push_back(tx_data);
            if (req_ready != '0) order_q.push_back(8'(grant_id));
        end
    endtask

    task automatic run_cycle();
        @(posedge clock);
        #1;
        drive_inputs();
        @(negedge clock);
        sample_and_check();
    endtask

    task automatic run_drain(input int budget);
        bit done;
        int c;
        c = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            run_cycle();
            c++;
            done = (m_owner < 0);
            for (int i = 0; i < N; i++) if (rd[i] != wr[i]) done = 1'b0;
        end
        check_eq("drain_done", done, 1);
    endtask

    // Synchronous reset: drop pending bytes, check reset values, restart model.
    task automatic do_reset(input int cycles);
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd[i] = wr[i]; m_rd[i] = wr[i]; gap[i] = 0;
        end
        @(negedge clock);
        for (int c = 1; c < cycles; c++) begin
            @(posedge clock);
            @(negedge clock);
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_tx_data", tx_data, 0);
            check_eq("rst_avail", tx_data_available, 0);
            check_eq("rst_grant_id", grant_id, 0);
            check_eq("rst_busy", busy, 0);
        end
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_last_grant = 0;
        m_tag = 1'b0; m_prev_fire = 1'b0;
        tx_hold = 0; just_fired = 1'b0;
        line_q.delete();
        order_q.delete();
        reset = 1'b0;
    endtask

    task automatic random_phase(input int cycles);
        int r, len;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                r   = int'($urandom_range(0, N - 1));
                len = int'($urandom_range(1, 7));
                if (wr[r] - rd[r] < 20 && wr[r] < DEPTH - 8) begin
                    if ($urandom_range(0, 2) == 0)
                        push_msg(r, len, int'($urandom_range(0, 6)), $urandom_range(1, 25));
                    else
                        push_msg(r, len, -1, 0);
                end
            end
            run_cycle();
        end
        run_drain(6000);
    endtask

    initial begin
        bq_t e;
        for (int i = 0; i < N; i++) begin
            wr[i] = 0; rd[i] = 0; gap[i] = 0; m_rd[i] = 0;
        end
        do_reset(3);

        // Single requester, "AB\n".
        push_byte(0, 8'h41, 1'b0, 0);
        push_byte(0, 8'h42, 1'b0, 0);
        push_byte(0, 8'h0A, 1'b1, 0);
        run_drain(500);
        e.delete();
        if (TAG_EN) e.push_back(8'h30);
        e.push_back(8'h41); e.push_back(8'h42); e.push_back(8'h0A);
        check_seq("line_ab", line_q, e);

        // Three simultaneous 1-byte messages, then requesters 0 and 2.
        do_reset(2);
        for (int i = 0; i < N; i++) push_msg(i, 1, -1, 0);
        run_drain(500);
        for (int i = 0; i < N; i++) if (i != 1) push_msg(i, 1, -1, 0);
        run_drain(500);
        e.delete();
        e.push_back(8'd0); e.push_back(8'd1); e.push_back(8'd2);
        e.push_back(8'd0); e.push_back(8'd2);
        check_seq("rr_order", order_q, e);

        // Sticky grant through a 20-cycle gap while requester 0 waits.
        do_reset(2);
        push_msg(1, 4, 1, 20);
        run_cycle();
        run_cycle();
        push_msg(0, 2, -1, 0);
        run_drain(1000);
        e.delete();
        for (int i = 0; i < 4; i++) e.push_back(8'd1);
        e.push_back(8'd0); e.push_back(8'd0);
        check_seq("sticky_order", order_q, e);

        // Byte-limit forced release: 6-byte message against a waiting requester.
        do_reset(2);
        push_msg(0, 6, -1, 0);
        push_msg(1, 3, -1, 0);
        run_drain(1500);
        e.delete();
        for (int i = 0; i < 4; i++) e.push_back(8'd0);
        for (int i = 0; i < 3; i++) e.push_back(8'd1);
        e.push_back(8'd0); e.push_back(8'd0);
        check_seq("limit_order", order_q, e);

        // Reset after the second byte of a 5-byte message.
        do_reset(2);
        begin
            int f0, c;
            push_msg(0, 5, -1, 0);
            f0 = m_fires;
            c  = 0;
            while (m_fires - f0 < 2 && c < 500) begin
                run_cycle();
                c++;
            end
            check_eq("two_fires_seen", m_fires - f0, 2);
        end
        do_reset(3);
        push_msg(2, 1, -1, 0);
        run_drain(500);
        e.delete();
        e.push_back(8'd2);
        check_seq("post_reset_order", order_q, e);

        // Requester 2 sends 'x' as a one-byte message.
        do_reset(2);
        push_byte(2, 8'h78, 1'b1, 0);
        run_drain(500);
        e.delete();
        if (TAG_EN) e.push_back(8'h32);
        e.push_back(8'h78);
        check_seq("line_x", line_q, e);

        // Randomized traffic with gaps and limit releases.
        do_reset(2);
        random_phase(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
